// File: rtl/vma_arb.sv
// vma_arb: VMA requester arbiter and memory-cycle sequencer (PI > EBOX > DIAG with DIAG anti-starvation).
// Define VMA_ARB_TIMEOUT_EN to add the WAIT no-response timeout counter and its error.
module vma_arb #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int DIAG_STARVE    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pi_req,
    input  logic       ebox_req,
    input  logic       diag_req,
    input  logic [1:0] pi_fn,
    input  logic [1:0] ebox_fn,
    input  logic [1:0] diag_fn,
    output logic [2:0] grant,
    output logic [1:0] vma_sel,
    output logic       vma_load,
    output logic       load_vma_held,
    input  logic       adr_brk_match,
    input  logic [2:0] adr_brk_cond,
    output logic       mem_start,
    output logic [1:0] mem_fn,
    input  logic       mem_ack,
    input  logic       mem_err,
    output logic       done,
    output logic       err,
    output logic       abrk_trap,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, WAIT, DONE} state_t;
    state_t     state;
    logic [3:0] starve;
    logic       diag_win, brk, to, fin;

    assign diag_win = diag_req && (!ebox_req || starve >= 4'(DIAG_STARVE));
    // Read-modify-write traps on either its read or its write enable
    assign brk = adr_brk_match && (mem_fn == 2'b10 ? adr_brk_cond[2] :
                                   mem_fn == 2'b00 ? adr_brk_cond[1] :
                                   mem_fn == 2'b01 ? adr_brk_cond[0] : |adr_brk_cond[1:0]);

`ifdef VMA_ARB_TIMEOUT_EN
    logic [7:0] tcnt;
    always_ff @(posedge clk) begin
        tcnt <= (reset || state != WAIT) ? 8'd0 : tcnt + 1'b1;
    end
    assign to = state == WAIT && tcnt == 8'(TIMEOUT_CYCLES);
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign to = 1'b0;
`endif

    // Completion strobes follow live inputs in CHECK/WAIT; reset suppresses them immediately
    assign fin           = !reset && state == WAIT && (mem_ack || mem_err || to);
    assign abrk_trap     = !reset && state == CHECK && brk;
    assign mem_start     = !reset && state == CHECK && !brk;
    assign load_vma_held = mem_start;
    assign done          = fin || abrk_trap;
    assign err           = fin && (mem_err || (to && !mem_ack));
    assign busy          = state != IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= 3'b000;
            vma_sel  <= 2'b11;
            mem_fn   <= 2'b00;
            vma_load <= 1'b0;
            starve   <= 4'd0;
        end else begin
            vma_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (!diag_req) starve <= 4'd0;
                    if (pi_req) begin
                        grant   <= 3'b100;
                        vma_sel <= 2'b01;
                        mem_fn  <= pi_fn;
                    end else if (diag_win) begin
                        grant   <= 3'b001;
                        vma_sel <= 2'b10;
                        mem_fn  <= diag_fn;
                        starve  <= 4'd0;
                    end else if (ebox_req) begin
                        grant   <= 3'b010;
                        vma_sel <= 2'b00;
                        mem_fn  <= ebox_fn;
                        if (diag_req && starve != 4'd15) starve <= starve + 1'b1;
                    end
                    if (pi_req || ebox_req || diag_req) begin
                        state    <= LOAD;
                        vma_load <= 1'b1;
                    end
                end
                LOAD: begin
                    vma_sel <= 2'b11;
                    state   <= CHECK;
                end
                CHECK: begin
                    if (brk) grant <= 3'b000;
                    state <= brk ? DONE : WAIT;
                end
                WAIT: begin
                    if (mem_ack || mem_err || to) begin
                        grant <= 3'b000;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vma_arb.sv
// tb_vma_arb: scenario tasks for vma_arb; completions are scored against a queue of expected {grant, err, trap}.
module tb_vma_arb;
    logic       clk = 1'b0, reset = 1'b1;
    logic       pi_req = 1'b0, ebox_req = 1'b0, diag_req = 1'b0;
    logic [1:0] pi_fn = 2'b00, ebox_fn = 2'b00, diag_fn = 2'b00;
    logic       adr_brk_match = 1'b0, mem_ack = 1'b0, mem_err = 1'b0;
    logic [2:0] adr_brk_cond = 3'b000;
    logic [2:0] grant;
    logic [1:0] vma_sel, mem_fn;
    logic       vma_load, load_vma_held, mem_start, done, err, abrk_trap, busy;
    int         checks = 0, passed = 0, starts = 0;
    logic [4:0] sb[$];
    logic [4:0] exp_c;

    always #5 clk = ~clk;

    vma_arb #(.TIMEOUT_CYCLES(8), .DIAG_STARVE(4)) dut (
        .clk(clk), .reset(reset),
        .pi_req(pi_req), .ebox_req(ebox_req), .diag_req(diag_req),
        .pi_fn(pi_fn), .ebox_fn(ebox_fn), .diag_fn(diag_fn),
        .grant(grant), .vma_sel(vma_sel), .vma_load(vma_load), .load_vma_held(load_vma_held),
        .adr_brk_match(adr_brk_match), .adr_brk_cond(adr_brk_cond),
        .mem_start(mem_start), .mem_fn(mem_fn), .mem_ack(mem_ack), .mem_err(mem_err),
        .done(done), .err(err), .abrk_trap(abrk_trap), .busy(busy)
    );

    // Every done pops the oldest expected completion
    always @(negedge clk) begin
        if (mem_start === 1'b1) starts++;
        if (done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_done: unexpected done grant=%b err=%b trap=%b", grant, err, abrk_trap);
            end else begin
                exp_c = sb.pop_front();
                if ({grant, err, abrk_trap} !== exp_c)
                    $display("FAIL sb_done: got grant/err/trap=%b want %b", {grant, err, abrk_trap}, exp_c);
                else
                    passed++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a grant, ack in the first WAIT cycle; returns in the DONE cycle
    task automatic run_grant(input logic e, output logic [2:0] g, output int lat);
        g = 3'b000;
        lat = 0;
        while (g === 3'b000 && lat < 20) begin
            tick();
            lat++;
            @(negedge clk);
            g = grant;
        end
        if (g === 3'b000) begin
            checks++;
            $display("FAIL run_grant: no grant within %0d cycles", lat);
            return;
        end
        tick();
        tick();
        mem_ack = 1'b1;
        mem_err = e;
        tick();
        mem_ack = 1'b0;
        mem_err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if ({grant, vma_sel, mem_fn, busy} !== 8'b000_11_00_0)
            $display("FAIL reset_state: got grant=%b vma_sel=%b mem_fn=%b busy=%b want 000 11 00 0", grant, vma_sel, mem_fn, busy);
        else passed++;
        checks++;
        if ({vma_load, load_vma_held, mem_start, done, err, abrk_trap} !== 6'b0)
            $display("FAIL reset_strobes: got %b want 000000", {vma_load, load_vma_held, mem_start, done, err, abrk_trap});
        else passed++;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_ebox();
        int bad = 0;
        tick();
        ebox_req = 1'b1;
        ebox_fn = 2'b00;
        sb.push_back(5'b010_0_0);
        tick();
        @(negedge clk);
        checks++;
        if ({grant, vma_sel, vma_load, mem_start} !== 7'b010_00_1_0)
            $display("FAIL ebox_c1: got grant=%b sel=%b load=%b start=%b want 010 00 1 0", grant, vma_sel, vma_load, mem_start);
        else passed++;
        tick();
        @(negedge clk);
        checks++;
        if ({vma_sel, vma_load, mem_start, load_vma_held, done} !== 6'b11_0_1_1_0)
            $display("FAIL ebox_c2: got sel=%b load=%b start=%b held=%b done=%b want 11 0 1 1 0", vma_sel, vma_load, mem_start, load_vma_held, done);
        else passed++;
        repeat (2) begin
            tick();
            @(negedge clk);
            if (done !== 1'b0 || mem_start !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL ebox_wait: %0d bad WAIT cycles, want 0", bad);
        else passed++;
        tick();
        mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({done, err} !== 2'b10) $display("FAIL ebox_c5: got done/err=%b want 10", {done, err});
        else passed++;
        tick();
        mem_ack = 1'b0;
        ebox_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({grant, busy, done} !== 5'b000_1_0) $display("FAIL ebox_c6: got grant=%b busy=%b done=%b want 000 1 0", grant, busy, done);
        else passed++;
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL ebox_c7: got busy=%b want 0", busy);
        else passed++;
    endtask

    task automatic test_simultaneous();
        logic [2:0] g, ge;
        logic [1:0] fe;
        int lat;
        tick();
        {pi_req, ebox_req, diag_req} = 3'b111;
        pi_fn = 2'b01;
        ebox_fn = 2'b11;
        diag_fn = 2'b10;
        for (int i = 0; i < 3; i++) begin
            ge = 3'b100 >> i;
            sb.push_back({ge, 2'b00});
        end
        for (int i = 0; i < 3; i++) begin
            ge = 3'b100 >> i;
            fe = i == 0 ? 2'b01 : i == 1 ? 2'b11 : 2'b10;
            run_grant(1'b0, g, lat);
            checks++;
            if (g !== ge || mem_fn !== fe || lat !== (i == 0 ? 1 : 2))
                $display("FAIL simul_%0d: got grant=%b fn=%b lat=%0d want %b %b %0d", i, g, mem_fn, lat, ge, fe, i == 0 ? 1 : 2);
            else passed++;
            if (g[2]) pi_req = 1'b0;
            if (g[1]) ebox_req = 1'b0;
            if (g[0]) diag_req = 1'b0;
            @(negedge clk);
            checks++;
            if ({grant, busy} !== 4'b000_1) $display("FAIL simul_dead_%0d: got grant=%b busy=%b want 000 1", i, grant, busy);
            else passed++;
        end
    endtask

    task automatic test_starvation();
        logic [2:0] g, ge;
        int lat;
        tick();
        ebox_req = 1'b1;
        diag_req = 1'b1;
        ebox_fn = 2'b00;
        diag_fn = 2'b00;
        for (int i = 0; i < 6; i++) sb.push_back({i == 4 ? 3'b001 : 3'b010, 2'b00});
        for (int i = 0; i < 6; i++) begin
            ge = i == 4 ? 3'b001 : 3'b010;
            run_grant(1'b0, g, lat);
            checks++;
            if (g !== ge) $display("FAIL starve_%0d: got grant=%b want %b", i, g, ge);
            else passed++;
            if (g[0]) diag_req = 1'b0;
        end
        ebox_req = 1'b0;
    endtask

    task automatic test_addr_break();
        logic [2:0] g;
        int lat, s0;
        for (int i = 0; i < 4; i++) begin
            tick();
            adr_brk_match = 1'b1;
            adr_brk_cond = i == 0 ? 3'b100 : i == 1 ? 3'b010 : 3'b001;
            ebox_fn = i == 0 ? 2'b10 : i == 2 ? 2'b01 : 2'b11;
            ebox_req = 1'b1;
            sb.push_back(5'b010_0_1);
            s0 = starts;
            tick();
            tick();
            @(negedge clk);
            checks++;
            if ({done, abrk_trap, mem_start, load_vma_held} !== 4'b1100)
                $display("FAIL brk_hit_%0d: got done/trap/start/held=%b want 1100", i, {done, abrk_trap, mem_start, load_vma_held});
            else passed++;
            tick();
            ebox_req = 1'b0;
            checks++;
            if ({grant, busy} !== 4'b000_1 || starts !== s0)
                $display("FAIL brk_after_%0d: got grant=%b busy=%b starts=%0d want 000 1 %0d", i, grant, busy, starts, s0);
            else passed++;
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            adr_brk_cond = i == 0 ? 3'b100 : 3'b011;
            ebox_fn = i == 0 ? 2'b00 : 2'b10;
            ebox_req = 1'b1;
            sb.push_back(5'b010_0_0);
            s0 = starts;
            run_grant(1'b0, g, lat);
            ebox_req = 1'b0;
            checks++;
            if (g !== 3'b010 || starts !== s0 + 1)
                $display("FAIL brk_miss_%0d: got grant=%b starts=%0d want 010 %0d", i, g, starts, s0 + 1);
            else passed++;
        end
        adr_brk_match = 1'b0;
        adr_brk_cond = 3'b000;
    endtask

    task automatic test_mem_errors();
        logic [2:0] g;
        int lat, early, lows;
        tick();
        ebox_req = 1'b1;
        ebox_fn = 2'b01;
        sb.push_back(5'b010_1_0);
        run_grant(1'b1, g, lat);
        ebox_req = 1'b0;
        tick();
        ebox_req = 1'b1;
        sb.push_back(5'b010_1_0);
        repeat (3) tick();
        mem_err = 1'b1;
        @(negedge clk);
        checks++;
        if ({done, err} !== 2'b11) $display("FAIL err_alone: got done/err=%b want 11", {done, err});
        else passed++;
        tick();
        mem_err = 1'b0;
        ebox_req = 1'b0;
`ifdef VMA_ARB_TIMEOUT_EN
        for (int k = 0; k < 2; k++) begin
            early = 0;
            tick();
            ebox_req = 1'b1;
            sb.push_back({3'b010, k == 0 ? 2'b10 : 2'b00});
            repeat (2) tick();
            repeat (8) begin
                tick();
                @(negedge clk);
                if (done !== 1'b0) early++;
            end
            tick();
            mem_ack = k == 1;
            @(negedge clk);
            checks++;
            if (early !== 0 || {done, err} !== {1'b1, k == 0})
                $display("FAIL timeout_%0d: got early=%0d done/err=%b want 0 1%b", k, early, {done, err}, k == 0);
            else passed++;
            tick();
            mem_ack = 1'b0;
            ebox_req = 1'b0;
        end
`else
        lows = 0;
        tick();
        ebox_req = 1'b1;
        sb.push_back(5'b010_0_0);
        repeat (300) begin
            tick();
            @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) lows++;
        end
        checks++;
        if (lows !== 0) $display("FAIL no_timeout: %0d cycles idle or done, want 0", lows);
        else passed++;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        ebox_req = 1'b0;
`endif
    endtask

    task automatic test_reset_in_wait();
        logic [2:0] g;
        int lat, s0;
        tick();
        ebox_req = 1'b1;
        ebox_fn = 2'b01;
        s0 = starts;
        repeat (3) tick();
        reset = 1'b1;
        ebox_req = 1'b0;
        tick();
        reset = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({grant, vma_sel, mem_fn, busy} !== 8'b000_11_00_0)
            $display("FAIL rst_wait_state: got grant=%b sel=%b fn=%b busy=%b want 000 11 00 0", grant, vma_sel, mem_fn, busy);
        else passed++;
        checks++;
        if ({vma_load, load_vma_held, mem_start, done, err, abrk_trap} !== 6'b0)
            $display("FAIL rst_wait_strobes: got %b want 000000", {vma_load, load_vma_held, mem_start, done, err, abrk_trap});
        else passed++;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || starts !== s0 + 1)
            $display("FAIL rst_wait_after: got busy=%b starts=%0d want 0 %0d", busy, starts, s0 + 1);
        else passed++;
        diag_req = 1'b1;
        diag_fn = 2'b10;
        sb.push_back(5'b001_0_0);
        run_grant(1'b0, g, lat);
        diag_req = 1'b0;
        checks++;
        if (g !== 3'b001 || lat !== 1 || mem_fn !== 2'b10)
            $display("FAIL rst_regrant: got grant=%b lat=%0d fn=%b want 001 1 10", g, lat, mem_fn);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_ebox();
        test_simultaneous();
        test_starvation();
        test_addr_break();
        test_mem_errors();
        test_reset_in_wait();
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) $display("FAIL sb_leftover: %0d completions never seen, want 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/vma_arb.md
# vma_arb

Arbiter and sequencer for the VMA register and address-break comparator. It selects one of three memory requesters (PI function cycle, EBOX microcode, diagnostic/console) and steers the VMA source select. It pulses the VMA and VMA HELD loads, checks the address-break match before starting memory, and tracks the memory handshake through to completion or error. It sits between the MCL/CON control logic and the VMA datapath.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: cycles in WAIT before a no-response error. Range 1–255; the counter is 8 bits.
- DIAG_STARVE, 4: consecutive EBOX grants allowed while DIAG is pending before DIAG wins once. Range 1–15.

Ports:
- clk  in  1  VMA clock, same domain as the VMA register.
- reset  in  1  Synchronous, active-high.
- pi_req, ebox_req, diag_req  in  1 each  Request lines; each requester holds its line until its own done.
- pi_fn, ebox_fn, diag_fn  in  2 each  Cycle type: 00 read, 01 write, 10 fetch, 11 read-modify-write.
- grant  out  3  One-hot {pi, ebox, diag}; held from LOAD until completion.
- vma_sel  out  2  VMA source: 00 EBOX AD, 01 PI function address, 10 diagnostic, 11 hold.
- vma_load  out  1  One-cycle VMA load strobe.
- load_vma_held  out  1  One-cycle VMA HELD load strobe.
- adr_brk_match  in  1  VMA[13:35] equals the address-break register.
- adr_brk_cond  in  3  Break enables {fetch, read, write}.
- mem_start  out  1  One-cycle memory start.
- mem_fn  out  2  Registered cycle type of the granted requester.
- mem_ack  in  1  Memory completion.
- mem_err  in  1  Memory error, qualified by mem_ack or standalone.
- done  out  1  One-cycle completion to the granted requester.
- err  out  1  One-cycle error, coincident with done.
- abrk_trap  out  1  One-cycle address-break trap, coincident with done.
- busy  out  1  High whenever state ≠ IDLE.

## Operation
State machine states: IDLE, LOAD, CHECK, WAIT, DONE.

- **IDLE**
  - Priority is PI > EBOX > DIAG.
  - Exception: if DIAG has been pending across DIAG_STARVE consecutive EBOX grants, DIAG beats EBOX once. The starvation counter then clears. PI always wins.
  - The winner is registered into grant and mem_fn, and vma_sel is set to its source. Next state is LOAD.
- **LOAD**
  - vma_load=1 and vma_sel = the granted source. Next state is CHECK.
- **CHECK**
  - The VMA now holds the address, so adr_brk_match is valid. vma_sel=11.
  - Break hits when adr_brk_match is high and the cycle type is enabled in adr_brk_cond:
    - fetch (10) uses the fetch enable;
    - read (00) uses the read enable;
    - write (01) uses the write enable;
    - read-modify-write (11) hits if either the read or the write enable is set.
  - On a break hit: abrk_trap=1 and done=1 in this cycle, no mem_start, next state is DONE.
  - Otherwise: mem_start=1 and load_vma_held=1, timeout counter cleared, next state is WAIT.
- **WAIT**
  - mem_ack without mem_err: done=1, next state is DONE.
  - mem_err (with or without mem_ack): done=1 and err=1, next state is DONE.
  - Timeout counter reaches TIMEOUT_CYCLES: done=1 and err=1, next state is DONE.
- **DONE**
  - grant drops. Next state is IDLE.
  - One dead cycle always separates consecutive grants.

Other rules:
- Requests are sampled only in IDLE. A requester that drops req mid-cycle is ignored and the cycle completes.
- A new request arriving during a cycle waits.
- The starvation counter increments on each EBOX grant while diag_req is high. It clears on any DIAG grant and whenever diag_req is low in IDLE. It saturates at 15.

## Timing
- Reset values: grant=000, vma_sel=11, mem_fn=00, busy=0. All strobes (vma_load, load_vma_held, mem_start, done, err, abrk_trap) are 0. State IDLE; timeout and starvation counters at 0.
- Request-to-strobe latency, with the request seen in IDLE at cycle 0:
  - grant and vma_load at cycle 1;
  - mem_start at cycle 2;
  - done no earlier than cycle 3;
  - next grant no earlier than done+2.
- Break trap path: done and abrk_trap at cycle 2, zero memory activity.
- Simultaneous mem_ack and timeout expiry: mem_ack wins, err=0 unless mem_err is also high.
- Simultaneous mem_ack and mem_err: error reported.
- Reset mid-cycle: every output returns to its reset value on the next edge. No done is issued and no mem_start is reissued.
- mem_ack seen in any state other than WAIT is ignored.

## Configuration
- VMA_ARB_TIMEOUT_EN defined: the timeout counter and timeout error are present.
- VMA_ARB_TIMEOUT_EN undefined: no counter; WAIT leaves only on mem_ack or mem_err. TIMEOUT_CYCLES is unused.

## Test plan
- **Single EBOX read:** ebox_req=1, ebox_fn=00, mem_ack three cycles after mem_start → grant=010 at cycle 1, vma_sel=00, vma_load at cycle 1, mem_start at cycle 2, done at cycle 5 with err=0, busy low at cycle 7.
- **Simultaneous requests:** pi/ebox/diag all requesting, each acked immediately → grant order PI, EBOX, DIAG; one dead cycle between grants.
- **Starvation (DIAG_STARVE=4):** EBOX re-requests continuously with diag_req=1 → 4 EBOX grants, then DIAG, then EBOX.
- **Address break:** adr_brk_cond=100, ebox_fn=10, adr_brk_match=1 → abrk_trap and done at cycle 2, mem_start never asserted. Repeat with ebox_fn=00 → normal cycle.
- **Memory errors:**
  - mem_err with mem_ack → done+err.
  - With VMA_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack → done+err 8 cycles into WAIT.
  - Without the macro, no ack → busy stays high indefinitely.
- **Reset in WAIT:** reset=1 for one cycle → all outputs at reset values, a later mem_ack is ignored, and a new request is granted normally.
